ddsrx: RTL

Serial-load receiver for the DDS configuration interface: watches the `ddswclk`/`ddsfqud`/`ddsdata`/`ddsreset` lines driven by the DDS configuration block and reconstructs the word the DDS chip will latch. It sits beside the DDS pins as a loopback monitor for built-in test: the firmware compares the captured word against what it commanded, and the block flags malformed frames. All four DDS lines are treated as asynchronous inputs and oversampled by the system clock.

---
 rtl/ddsrx.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ddsrx.sv
// ddsrx: loopback monitor for the DDS serial configuration lines.
// Oversamples wclk/fqud/data/reset, rebuilds the word the DDS chip latches on
// each fqud rise, and flags frames whose bit count is not WORD_BITS.
//
// state | meaning
// IDLE  | no bits collected yet, waiting for the first wclk rise
// SHIFT | collecting bits of an open frame
// HOLD  | frame just closed, waiting for fqud to drop
module ddsrx #(
  parameter int WORD_BITS   = 40,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ddswclk,
  input  logic                 ddsfqud,
  input  logic                 ddsdata,
  input  logic                 ddsreset,
  output logic [WORD_BITS-1:0] rx_word,
  output logic                 rx_valid,
  output logic                 rx_err,
  output logic [5:0]           rx_count,
  output logic [7:0]           rx_frames,
  output logic                 dds_in_reset
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  localparam logic [5:0] WB  = 6'(WORD_BITS);
  localparam logic [6:0] WB7 = 7'(WORD_BITS);

  // line order in the synchronizer: {ddsreset, ddsdata, ddsfqud, ddswclk}
  logic [3:0]             sync_q [SYNC_STAGES];
  logic [1:0]             prev_q;
  // Tracks which pipeline stages hold real samples since reset; edges are
  // only trusted once prev_q was loaded from a real sample, so a line held
  // high across reset release never looks like a rising edge.
  logic [SYNC_STAGES:0]   vld_q;

  logic [3:0]             lines_s;
  logic                   wclk_rise, fqud_rise, data_s, rst_s, fqud_s;

  state_t                 state_q, state_d;
  logic [WORD_BITS-1:0]   shreg_q, shreg_d;
  logic [5:0]             count_q, count_d;
  logic [WORD_BITS-1:0]   word_q, word_d;
  logic                   err_q, err_d;
  logic                   valid_q, valid_d;
  logic [7:0]             frames_q, frames_d;

  logic [WORD_BITS-1:0]   sh_tmp;
  logic [5:0]             cnt_tmp;
  logic [6:0]             shamt;

  assign lines_s   = sync_q[SYNC_STAGES-1];
  assign wclk_rise = lines_s[0] & ~prev_q[0] & vld_q[SYNC_STAGES];
  assign fqud_rise = lines_s[1] & ~prev_q[1] & vld_q[SYNC_STAGES];
  assign fqud_s    = lines_s[1];
  assign data_s    = lines_s[2];
  assign rst_s     = lines_s[3];

  // Synchronizer chain, edge-detect history and sample-valid tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      vld_q  <= '0;
    end else begin
      sync_q[0] <= {ddsreset, ddsdata, ddsfqud, ddswclk};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= lines_s[1:0];
      vld_q  <= {vld_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // State and frame registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      count_q  <= '0;
      word_q   <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      count_q  <= count_d;
      word_q   <= word_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      frames_q <= frames_d;
    end
  end

  // Bit capture, frame close and state transitions
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    count_d  = count_q;
    word_d   = word_q;
    err_d    = err_q;
    valid_d  = 1'b0;
    frames_d = frames_q;
    sh_tmp   = shreg_q;
    cnt_tmp  = count_q;
    shamt    = '0;

    if (rst_s) begin
      shreg_d = '0;
      count_d = '0;
      state_d = IDLE;
    end else begin
      // A bit arriving together with fqud is shifted first, then closed.
      if (wclk_rise) begin
        if (count_q < WB) sh_tmp = {data_s, shreg_q[WORD_BITS-1:1]};
        cnt_tmp = (count_q == 6'd63) ? 6'd63 : count_q + 6'd1;
      end
      shreg_d = sh_tmp;
      count_d = cnt_tmp;

      case (state_q)
        IDLE:    if (wclk_rise) state_d = SHIFT;
        SHIFT:   state_d = SHIFT;
        HOLD:    if (!fqud_s) state_d = (cnt_tmp != 6'd0) ? SHIFT : IDLE;
        default: state_d = IDLE;
      endcase

      if (fqud_rise) begin
        // Short frames sit in the top of shreg; slide them down to bit 0.
        shamt    = (cnt_tmp >= WB) ? 7'd0 : WB7 - {1'b0, cnt_tmp};
        word_d   = sh_tmp >> shamt;
        err_d    = (cnt_tmp != WB);
        valid_d  = 1'b1;
        frames_d = frames_q + 8'd1;
        shreg_d  = '0;
        count_d  = '0;
        state_d  = HOLD;
      end
    end
  end

  assign rx_word      = word_q;
  assign rx_valid     = valid_q;
  assign rx_err       = err_q;
  assign rx_count     = count_q;
  assign rx_frames    = frames_q;
  assign dds_in_reset = rst_s;

endmodule
